// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed 8-digit seven-segment driver for a common-anode display.
// A 32-bit count is shown as 8 hex digits; digit k shows value[4k+3:4k].
// The value is captured into a shadow register once per scan frame, so the
// display never tears mid-frame.
//
// Parameters
//   SCAN_DIV    clock cycles each digit stays lit (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   value       32-bit count to display
//   hold        1 = suppress the frame-boundary capture (display freezes)
//   force_load  1 = capture value on the next edge regardless of hold
//   dp_in       per-digit decimal point, active-high, not shadowed
//   an          digit enables, active-low, one-hot-low after reset
//   seg         segments {g,f,e,d,c,b,a}, active-low
//   dp          decimal point, active-low
//   frame_done  one-cycle pulse after each frame-boundary edge
//
// Build option
//   SEG_LZ_BLANK_EN  when defined, leading zeros (digits 1..7) are blanked
// -----------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value,
  input  logic        hold,
  input  logic        force_load,
  input  logic [7:0]  dp_in,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       dig;
  logic [31:0]      shadow;

  logic             tick;
  logic             frame_edge;
  logic             capture;
  logic [3:0]       nib;
  logic             blank;
  logic [6:0]       seg_next;

  // Hex to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick       = (div_cnt == DIV_LAST);
  assign frame_edge = tick && (dig == 3'd7);
  // force_load and a frame boundary on the same edge both load the same
  // value, so a plain OR gives the single capture.
  assign capture    = force_load || (frame_edge && !hold);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    blank    = 1'b0;
    nib      = shadow[{dig, 2'b00} +: 4];
`ifdef SEG_LZ_BLANK_EN
    // Blank digit k > 0 when it and every more-significant nibble are zero.
    blank    = (dig != 3'd0) && ((shadow >> {dig, 2'b00}) == 32'd0);
`endif
    seg_next = blank ? 7'h7F : hex_to_seg(nib);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours, independent of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      dig     <= 3'd0;
    end else if (tick) begin
      div_cnt <= '0;
      dig     <= dig + 3'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // NOTE: the shadow register is reset even though it is data, because the
  // display must show "0" immediately after reset rather than garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (capture) begin
      shadow <= value;
    end
  end

  // Outputs are registered from the current dig/shadow, so they lag by one
  // cycle and reach the pins glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= 8'hFF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= ~(8'd1 << dig);
      seg        <= seg_next;
      dp         <= ~dp_in[dig];
      frame_done <= frame_edge;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Two instances share stimulus: SCAN_DIV=4 (frame = 32 cycles) and
// SCAN_DIV=1 (frame = 8 cycles). A behavioural model derives every output
// from the number of edges since reset release: the digit shown after edge n
// is ((n-1)/SCAN_DIV) mod 8, a frame boundary is an edge n that is a multiple
// of 8*SCAN_DIV, and the shadow is whatever was last captured. A negedge
// process compares both instances every cycle; a directed sequence adds
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value;
  logic        hold;
  logic        force_load;
  logic [7:0]  dp_in;

  logic [7:0]  an_w  [2];
  logic [6:0]  seg_w [2];
  logic        dp_w  [2];
  logic        fd_w  [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(4)) u_div4 (
    .clk(clk), .rst_n(rst_n), .value(value), .hold(hold),
    .force_load(force_load), .dp_in(dp_in),
    .an(an_w[0]), .seg(seg_w[0]), .dp(dp_w[0]), .frame_done(fd_w[0])
  );

  seg_scan_driver #(.SCAN_DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .value(value), .hold(hold),
    .force_load(force_load), .dp_in(dp_in),
    .an(an_w[1]), .seg(seg_w[1]), .dp(dp_w[1]), .frame_done(fd_w[1])
  );

`ifdef SEG_LZ_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'h40;
`endif

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic int d_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [31:0] sh, input int k);
    logic [31:0] rest;
    rest = sh >> (4 * k);
`ifdef SEG_LZ_BLANK_EN
    if (k > 0 && rest == 32'd0) return 7'h7F;
`endif
    return SEG_TAB[rest[3:0]];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_n   [2];   // edges since reset release
  logic [31:0] m_sh  [2];   // last captured value
  logic [31:0] m_vis [2];   // shadow the outputs were computed from
  logic [7:0]  m_dpin;      // dp_in seen at the last edge

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_n[i]   <= 0;
        m_sh[i]  <= '0;
        m_vis[i] <= '0;
      end
    end else begin
      m_dpin <= dp_in;
      for (int i = 0; i < 2; i++) begin
        m_n[i]   <= m_n[i] + 1;
        m_vis[i] <= m_sh[i];
        if (force_load || ((((m_n[i] + 1) % (8 * d_of(i))) == 0) && !hold))
          m_sh[i] <= value;
      end
    end
  end

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [7:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      logic       e_fd;
      int         dg;
      if (m_n[i] == 0) begin
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      end else begin
        dg    = ((m_n[i] - 1) / d_of(i)) % 8;
        e_an  = ~(8'd1 << dg);
        e_seg = exp_seg(m_vis[i], dg);
        e_dp  = ~m_dpin[dg];
        e_fd  = ((m_n[i] % (8 * d_of(i))) == 0);
      end
      check(i == 0 ? "d4_an"  : "d1_an",  {24'd0, an_w[i]},  {24'd0, e_an});
      check(i == 0 ? "d4_seg" : "d1_seg", {25'd0, seg_w[i]}, {25'd0, e_seg});
      check(i == 0 ? "d4_dp"  : "d1_dp",  {31'd0, dp_w[i]},  {31'd0, e_dp});
      check(i == 0 ? "d4_fd"  : "d1_fd",  {31'd0, fd_w[i]},  {31'd0, e_fd});
    end
  end

  // ---------------- stimulus and literal checks ----------------
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Advance until the SCAN_DIV=4 instance shows the given anode pattern.
  task automatic seek(input logic [7:0] tgt, input string name);
    int n;
    n = 0;
    while (an_w[0] !== tgt && n < 40) begin
      step(1);
      n++;
    end
    check(name, {24'd0, an_w[0]}, {24'd0, tgt});
  endtask

  initial begin
    logic [7:0] dpv;
    int         fd_cnt;

    value      = 32'h1234ABCD;
    hold       = 1'b0;
    force_load = 1'b0;
    dp_in      = 8'hA5;
    step(3);
    check("rst_an",  {24'd0, an_w[0]},  32'hFF);
    check("rst_seg", {25'd0, seg_w[0]}, 32'h7F);
    check("rst_dp",  {31'd0, dp_w[0]},  32'h1);

    rst_n = 1'b1;
    dpv   = '0;
    for (int e = 1; e <= 8; e++) begin
      step(1);
      dpv[e-1] = dp_w[1];
      if (e == 1) begin
        check("first_an",  {24'd0, an_w[0]},  32'hFE);
        check("first_seg", {25'd0, seg_w[0]}, 32'h40);
        check("first_dp",  {31'd0, dp_w[0]},  32'h0);
      end
    end
    // dp low exactly for digits 0,2,5,7 of dp_in = A5
    check("div1_dp_seq", {24'd0, dpv}, 32'h5A);

    step(24);                                              // edge 32
    check("first_frame_done", {31'd0, fd_w[0]}, 32'h1);
    step(1);                                               // edge 33
    check("dig0_d",  {25'd0, seg_w[0]}, 32'h21);
    step(4);                                               // edge 37
    check("dig1_an", {24'd0, an_w[0]},  32'hFD);
    check("dig1_C",  {25'd0, seg_w[0]}, 32'h46);
    step(24);                                              // edge 61
    check("dig7_an", {24'd0, an_w[0]},  32'h7F);
    check("dig7_1",  {25'd0, seg_w[0]}, 32'h79);

    // Freeze: value changes mid-frame but the display keeps 1234ABCD.
    hold = 1'b1;
    step(5);
    value  = 32'hFFFFFFFF;
    fd_cnt = 0;
    for (int e = 0; e < 96; e++) begin
      step(1);
      if (fd_w[0]) fd_cnt++;
    end
    check("hold_fd_count", fd_cnt, 3);
    seek(8'hFE, "hold_seek_dig0");
    check("hold_dig0_d", {25'd0, seg_w[0]}, 32'h21);

    // force_load wins over hold.
    value      = 32'h00000005;
    force_load = 1'b1;
    step(1);
    force_load = 1'b0;
    value      = 32'hFFFFFFFF;
    step(1);
    seek(8'hFE, "force_seek_dig0");
    check("force_dig0_5", {25'd0, seg_w[0]}, 32'h12);
    seek(8'hFD, "force_seek_dig1");
    check("force_dig1_lz", {25'd0, seg_w[0]}, {25'd0, LZ_SEG});
    seek(8'h7F, "force_seek_dig7");
    check("force_dig7_lz", {25'd0, seg_w[0]}, {25'd0, LZ_SEG});

    // Randomized traffic, checked by the model every cycle.
    hold = 1'b0;
    for (int e = 0; e < 500; e++) begin
      value      = $urandom;
      hold       = ($urandom_range(0, 3) == 0);
      force_load = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) dp_in = 8'($urandom);
      step(1);
    end
    hold       = 1'b0;
    force_load = 1'b0;
    value      = 32'h0000F00D;

    // Asynchronous reset in the middle of digit 5.
    seek(8'hDF, "seek_dig5");
    step(1);
    rst_n = 1'b0;
    #1;
    check("async_rst_an",  {24'd0, an_w[0]},  32'hFF);
    check("async_rst_seg", {25'd0, seg_w[0]}, 32'h7F);
    check("async_rst_dp",  {31'd0, dp_w[0]},  32'h1);
    check("async_rst_fd",  {31'd0, fd_w[0]},  32'h0);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("restart_an",  {24'd0, an_w[0]},  32'hFE);
    check("restart_seg", {25'd0, seg_w[0]}, 32'h40);
    check("restart_dp",  {31'd0, dp_w[0]},  {31'd0, ~dp_in[0]});
    step(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed 8-digit seven-segment display driver that consumes a 32-bit count value, such as a cycle, branch or instruction counter, and shows it as 8 hexadecimal digits. It sits between the statistics counters and the board's common-anode display pins. It samples its input once per full scan frame, so the display never tears mid-frame.

## Interface
- `SCAN_DIV`, default 100000: clock cycles each digit stays lit; legal range ≥ 1.
- `clk`  in  1  system clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `value`  in  32  count to display; digit k shows `value[4k+3:4k]`.
- `hold`  in  1  when 1, the frame-boundary capture is suppressed and the display freezes.
- `force_load`  in  1  when 1, `value` is captured into the shadow register on the next edge, regardless of `hold`.
- `dp_in`  in  8  per-digit decimal point, active-high, not shadowed.
- `an`  out  8  digit enables, active-low, exactly one low after reset.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.
- `frame_done`  out  1  one-cycle pulse on each frame-boundary edge.

## Operation
- Prescaler `div_cnt` counts 0..SCAN_DIV-1.
  - Width is `$clog2(SCAN_DIV)`, minimum 1.
  - `tick` = (`div_cnt` == SCAN_DIV-1).
  - On `tick`, `div_cnt` wraps to 0.
- Digit index `dig` (3 bits) increments on `tick`; it wraps 7→0.
- Frame boundary: the edge where `tick` is true and `dig` == 7. On that edge:
  - `frame_done` is 1 for exactly one cycle.
  - `shadow` ← `value`, unless `hold` = 1.
- `force_load` = 1: `shadow` ← `value` on that edge.
  - It wins over `hold`.
  - Coincident with a frame boundary, a single capture occurs (same value).
- Decode is hex, active-low g..a: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Output registers:
  - `an` ← ~(1 << `dig`).
  - `seg` ← decode(`shadow` nibble `dig`).
  - `dp` ← ~`dp_in[dig]`.
  - All three are computed from the current `dig`/`shadow`, i.e. one cycle behind them.
- Reset, asserted at any time, including mid-frame:
  - `div_cnt`=0, `dig`=0, `shadow`=0, `an`=8'hFF, `seg`=7'h7F, `dp`=1, `frame_done`=0.
  - Effect is immediate (asynchronous). Release is synchronized by the first clock edge.

## Timing
- First edge after `rst_n` rises: `an`=8'hFE, `seg`=7'h40 ("0"), `dp`=~`dp_in[0]`.
- Digit k is visible for exactly SCAN_DIV cycles; a full frame is 8×SCAN_DIV cycles.
- `frame_done` period is 8×SCAN_DIV cycles. The first pulse arrives 8×SCAN_DIV cycles after reset release.
- A captured `shadow` appears on `seg` one cycle after capture, for whichever digit is selected then.
- SCAN_DIV=1: `dig` advances every cycle, and `frame_done` pulses every 8th cycle.
- `value` changes between frame boundaries have no visible effect unless `force_load` is asserted.

## Configuration
- `SEG_LZ_BLANK_EN` defined: leading-zero blanking.
  - Any digit k > 0 with `shadow[31:4k]` == 0 drives `seg`=7'h7F.
  - Its `an` is still asserted, and `dp` is unaffected.
  - Digit 0 is never blanked, so 0 displays as "0".
- Undefined: all 8 digits are always decoded, so 0 displays as "00000000".

## Test plan
- Reset, SCAN_DIV=4, `value`=32'h1234ABCD held: `an` sequence FE,FD,FB,…,7F, each held 4 cycles.
  - First frame shows all "0" (seg 40).
  - After the first `frame_done`, digits 0..7 show d,C,b,A,4,3,2,1 (seg 21,46,03,08,19,30,24,79).
- `hold`=1, `value` changed to 32'hFFFFFFFF mid-frame: the display keeps 32'h1234ABCD across 3 frames. `frame_done` still pulses every 32 cycles.
- `hold`=1 and `force_load`=1 for one cycle with `value`=32'h00000005: digit 0 shows seg 12 on the next visit.
  - With `SEG_LZ_BLANK_EN` defined, digits 1..7 show seg 7F.
  - Without it, digits 1..7 show seg 40.
- `rst_n` pulsed low mid-frame at `dig`=5: `an`=FF and `seg`=7F asynchronously. After release, the scan restarts at digit 0 with `shadow`=0.
- SCAN_DIV=1, `dp_in`=8'hA5: `dig` cycles every clock, and `dp` is low exactly when `dig` ∈ {0,2,5,7}, lagging `dig` by one cycle.
